// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEFAULT_BAUD        = 3_000_000;

    // Rounded to the nearest whole clock.
    function automatic int unsigned clks_per_bit(input int unsigned clk, input int unsigned baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8O1 UART receiver with valid/ready holding register and parity/frame/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned BAUD        = DEFAULT_BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             acc_q, acc_d;
    logic             par_ok_q, par_ok_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             good_byte;
    logic             transfer;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        par_ok_d  = par_ok_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        good_byte = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        acc_d     = 1'b0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    acc_d     = acc_q ^ rx_s;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    par_ok_d = acc_q ^ rx_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                // Leave at the stop mid-point so an immediately following start edge is caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (!par_ok_q) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        good_byte = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign transfer = valid_q & i_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~transfer;
        ovr_d   = 1'b0;
        if (good_byte) begin
            if (!valid_q || transfer) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            acc_q     <= 1'b0;
            par_ok_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            par_ok_q  <= par_ok_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven at real 3 Mbaud timing, compared against a byte-level model.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam real BIT_NS = 1.0e9 / 3.0e6;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_overrun;

    uart_rx #(.CLK_FREQ_HZ(100_000_000), .BAUD(3_000_000)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Observation side: only this process writes these.
    int         cyc = 0;
    logic [7:0] got [0:255];
    int         got_cyc [0:255];
    int         got_n = 0;
    int         n_perr = 0, n_ferr = 0, n_ovr = 0, n_unstable = 0;
    int         perr_cyc = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_valid && i_ready && got_n < 256) begin
            got[got_n]     = o_data;
            got_cyc[got_n] = cyc;
            got_n          = got_n + 1;
        end
        if (o_parity_err) begin
            n_perr   = n_perr + 1;
            perr_cyc = cyc;
        end
        if (o_frame_err) n_ferr = n_ferr + 1;
        if (o_overrun)   n_ovr  = n_ovr + 1;
        if (hold_prev && o_data !== data_prev) n_unstable = n_unstable + 1;
        hold_prev = o_valid && !i_ready;
        data_prev = o_data;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Odd parity: data ones plus parity bit must total an odd count.
    function automatic logic odd_parity_bit(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic drive_frame(input logic [7:0] b, input bit flip_par,
                               input bit zero_stop, input int extra_low_bits);
        logic [7:0] bits;
        bits = b;
        i_rx = 1'b0;
        #(BIT_NS);
        for (int k = 0; k < 8; k++) begin
            i_rx = bits[k];
            #(BIT_NS);
        end
        i_rx = odd_parity_bit(b) ^ flip_par;
        #(BIT_NS);
        i_rx = ~zero_stop;
        #(BIT_NS);
        if (zero_stop) begin
            #(BIT_NS * extra_low_bits);
            i_rx = 1'b1;
            #(BIT_NS);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        repeat (4) @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
        checks++; if ({o_parity_err, o_frame_err, o_overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {o_parity_err, o_frame_err, o_overrun});
        end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] list [9] = '{8'h5A, 8'hD1, 8'h17, 8'h22, 8'hAA, 8'hFD, 8'h90, 8'h0C, 8'h34};
        int base_got, base_err, start, lat;
        base_got = got_n;
        base_err = n_perr + n_ferr + n_ovr;
        start    = cyc;
        for (int i = 0; i < 9; i++) drive_frame(list[i], 1'b0, 1'b0, 0);
        #(2 * BIT_NS);
        checks++; if (got_n - base_got !== 9) begin
            errors++; $display("FAIL b2b_count: got %0d bytes want 9", got_n - base_got);
        end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[base_got + i] !== list[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[base_got + i], list[i]);
            end
        end
        lat = got_cyc[base_got] - start;
        checks++; if (lat < 348 || lat > 350) begin
            errors++; $display("FAIL b2b_latency: got %0d cycles want 349+-1", lat);
        end
        checks++; if (n_perr + n_ferr + n_ovr !== base_err) begin
            errors++; $display("FAIL b2b_errflags: got %0d new pulses want 0", n_perr + n_ferr + n_ovr - base_err);
        end
    endtask

    task automatic test_parity_error();
        int base_got, base_perr, base_ferr, start, lat;
        base_got  = got_n;
        base_perr = n_perr;
        base_ferr = n_ferr;
        start     = cyc;
        drive_frame(8'h5A, 1'b1, 1'b0, 0);
        #(BIT_NS);
        checks++; if (n_perr - base_perr !== 1) begin
            errors++; $display("FAIL par_pulse: got %0d pulses want 1", n_perr - base_perr);
        end
        lat = perr_cyc - start;
        checks++; if (lat < 346 || lat > 350) begin
            errors++; $display("FAIL par_latency: got %0d cycles want 346..350", lat);
        end
        checks++; if (got_n !== base_got || n_ferr !== base_ferr) begin
            errors++; $display("FAIL par_drop: got %0d bytes %0d frame errs want 0 0", got_n - base_got, n_ferr - base_ferr);
        end
        drive_frame(8'hD1, 1'b0, 1'b0, 0);
        #(BIT_NS);
        checks++; if (got_n - base_got !== 1 || got[base_got] !== 8'hD1) begin
            errors++; $display("FAIL par_next: got %0d bytes first %h want 1 d1", got_n - base_got, got[base_got]);
        end
    endtask

    task automatic test_frame_error();
        int base_got, base_perr, base_ferr;
        base_got  = got_n;
        base_perr = n_perr;
        base_ferr = n_ferr;
        drive_frame(8'h17, 1'b0, 1'b1, 2);
        #(BIT_NS);
        checks++; if (n_ferr - base_ferr !== 1) begin
            errors++; $display("FAIL frm_pulse: got %0d pulses want 1", n_ferr - base_ferr);
        end
        checks++; if (n_perr !== base_perr || got_n !== base_got) begin
            errors++; $display("FAIL frm_only: got %0d parity errs %0d bytes want 0 0", n_perr - base_perr, got_n - base_got);
        end
        drive_frame(8'h22, 1'b0, 1'b0, 0);
        #(BIT_NS);
        checks++; if (got_n - base_got !== 1 || got[base_got] !== 8'h22) begin
            errors++; $display("FAIL frm_next: got %0d bytes first %h want 1 22", got_n - base_got, got[base_got]);
        end
    endtask

    task automatic test_glitch();
        int base_sum;
        base_sum = got_n + n_perr + n_ferr + n_ovr;
        @(posedge i_clk); #2;
        i_rx = 1'b0;
        repeat (10) @(posedge i_clk);
        #2 i_rx = 1'b1;
        repeat (15) @(negedge i_clk);
        checks++; if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q);
        end
        #(2 * BIT_NS);
        checks++; if (got_n + n_perr + n_ferr + n_ovr !== base_sum) begin
            errors++; $display("FAIL glitch_outputs: got %0d events want 0", got_n + n_perr + n_ferr + n_ovr - base_sum);
        end
    endtask

    task automatic test_overrun();
        int base_got, base_ovr, base_unst;
        base_got  = got_n;
        base_ovr  = n_ovr;
        base_unst = n_unstable;
        @(posedge i_clk); #1 i_ready = 1'b0;
        drive_frame(8'hAA, 1'b0, 1'b0, 0);
        drive_frame(8'hFD, 1'b0, 1'b0, 0);
        #(BIT_NS);
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b1 || o_data !== 8'hAA) begin
            errors++; $display("FAIL ovr_hold: got valid %b data %h want 1 aa", o_valid, o_data);
        end
        checks++; if (n_ovr - base_ovr !== 1) begin
            errors++; $display("FAIL ovr_pulse: got %0d pulses want 1", n_ovr - base_ovr);
        end
        checks++; if (n_unstable !== base_unst) begin
            errors++; $display("FAIL ovr_stable: got %0d data changes while held want 0", n_unstable - base_unst);
        end
        @(posedge i_clk); #1 i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (got_n - base_got !== 1 || got[base_got] !== 8'hAA) begin
            errors++; $display("FAIL ovr_xfer: got %0d bytes first %h want 1 aa", got_n - base_got, got[base_got]);
        end
        checks++; if (o_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_release: got valid %b want 0", o_valid);
        end
        drive_frame(8'h90, 1'b0, 1'b0, 0);
        #(BIT_NS);
        checks++; if (got_n - base_got !== 2 || got[base_got + 1] !== 8'h90) begin
            errors++; $display("FAIL ovr_next: got %0d bytes last %h want 2 90", got_n - base_got, got[base_got + 1]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int base_got, base_err;
        b = 8'h0C;
        i_rx = 1'b0;
        #(BIT_NS);
        for (int k = 0; k < 4; k++) begin
            i_rx = b[k];
            #(BIT_NS);
        end
        i_rx = b[4];
        #(BIT_NS / 2);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checks++; if ({o_valid, o_parity_err, o_frame_err, o_overrun} !== 4'b0000 || o_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs: got v%b p%b f%b o%b d%h want all 0",
                               o_valid, o_parity_err, o_frame_err, o_overrun, o_data);
        end
        #(BIT_NS / 2);
        for (int k = 5; k < 8; k++) begin
            i_rx = b[k];
            #(BIT_NS);
        end
        i_rx = odd_parity_bit(b);
        #(BIT_NS);
        i_rx = 1'b1;
        #(BIT_NS);
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        base_got = got_n;
        base_err = n_perr + n_ferr + n_ovr;
        #(BIT_NS);
        drive_frame(8'h34, 1'b0, 1'b0, 0);
        #(BIT_NS);
        checks++; if (n_perr + n_ferr + n_ovr !== base_err) begin
            errors++; $display("FAIL rstmid_noerr: got %0d pulses want 0", n_perr + n_ferr + n_ovr - base_err);
        end
        checks++; if (got_n - base_got !== 1 || got[base_got] !== 8'h34) begin
            errors++; $display("FAIL rstmid_next: got %0d bytes first %h want 1 34", got_n - base_got, got[base_got]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        bit         flip;
        int         exp_perr, base_got, base_perr;
        base_got  = got_n;
        base_perr = n_perr;
        exp_perr  = 0;
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            drive_frame(b, flip, 1'b0, 0);
            if (flip) exp_perr++;
            else exp_q.push_back(b);
            #(BIT_NS * $urandom_range(0, 2));
        end
        #(BIT_NS);
        checks++; if (got_n - base_got !== exp_q.size()) begin
            errors++; $display("FAIL rnd_count: got %0d bytes want %0d", got_n - base_got, exp_q.size());
        end
        checks++; if (n_perr - base_perr !== exp_perr) begin
            errors++; $display("FAIL rnd_perr: got %0d want %0d", n_perr - base_perr, exp_perr);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got[base_got + i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_byte%0d: got %h want %h", i, got[base_got + i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity_error();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
